// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier (seq_mult_acc).
package mult_pkg;

  localparam int unsigned MaxW = 64;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic int unsigned prod_width(input int unsigned din_w, input int unsigned coeff_w);
    return din_w + coeff_w;
  endfunction

  function automatic int unsigned out_width(input int unsigned prod_w, input int unsigned guard_w);
    return prod_w + guard_w;
  endfunction

  function automatic int unsigned iter_count(input int unsigned coeff_w,
                                             input int unsigned radix_bits);
    return coeff_w / radix_bits;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Magnitude of a w-bit operand; the most-negative value maps to 2^(w-1).
  function automatic logic [MaxW-1:0] abs_mag(input logic [MaxW-1:0] v, input int unsigned w,
                                               input logic signed_mode);
    logic [MaxW-1:0] mask;
    logic            sgn;
    mask = (w >= MaxW) ? '1 : ((MaxW'(1) << w) - MaxW'(1));
    sgn  = |((v >> (w - 1)) & MaxW'(1));
    if (signed_mode && sgn) return (~v + MaxW'(1)) & mask;
    return v & mask;
  endfunction

  function automatic logic [MaxW-1:0] cond_neg(input logic [MaxW-1:0] v, input logic neg);
    return neg ? (~v + MaxW'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_pp_add.sv
// One radix step: |din| times a coefficient slice, shifted into place and added to the sum.
module mult_pp_add #(
  parameter int unsigned DIN_W      = 12,
  parameter int unsigned RADIX_BITS = 1,
  parameter int unsigned PROD_W     = 28,
  parameter int unsigned SH_W       = 4
) (
  input  logic [DIN_W-1:0]      mcand,
  input  logic [RADIX_BITS-1:0] slice,
  input  logic [SH_W-1:0]       shamt,
  input  logic [PROD_W-1:0]     psum_in,
  output logic [PROD_W-1:0]     psum_out
);

  logic [PROD_W-1:0] pp;

  always_comb begin
    pp       = PROD_W'(mcand) * PROD_W'(slice);
    psum_out = psum_in + (pp << shamt);
  end

endmodule

// File: rtl/seq_mult_acc.sv
// Multi-cycle sign-magnitude shift-add multiplier with valid/ready on both sides.
// Define MULT_ACC_EN to enable accumulate mode (acc_en sampled at accept).
module seq_mult_acc
  import mult_pkg::*;
#(
  parameter int unsigned DIN_W      = 12,
  parameter int unsigned COEFF_W    = 16,
  parameter int unsigned RADIX_BITS = 1,
  parameter int unsigned GUARD_W    = 4,
  localparam int unsigned PROD_W    = prod_width(DIN_W, COEFF_W),
  localparam int unsigned OUT_W     = out_width(PROD_W, GUARD_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIN_W-1:0]   din,
  input  logic [COEFF_W-1:0] coeff,
  input  logic               signed_mode,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   product,
  output logic               busy
);

  localparam int unsigned ITER  = iter_count(COEFF_W, RADIX_BITS);
  localparam int unsigned CNT_W = idx_width(ITER);
  localparam int unsigned SH_W  = idx_width(COEFF_W);

  state_e             state_q;
  logic [DIN_W-1:0]   din_mag_q, din_mag_d;
  logic [COEFF_W-1:0] coeff_mag_q, coeff_mag_d;
  logic               neg_q, neg_d, smode_q;
  logic [PROD_W-1:0]  psum_q, psum_next, signed_prod;
  logic [CNT_W-1:0]   cnt_q;
  logic [SH_W-1:0]    shamt;
  logic [OUT_W-1:0]   product_q, prod_ext, product_d;
  logic               out_valid_q;
  logic               accept;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == StBusy);
  assign out_valid = out_valid_q;
  assign product   = product_q;

  always_comb begin
    din_mag_d   = DIN_W'(abs_mag(MaxW'(din), DIN_W, signed_mode));
    coeff_mag_d = COEFF_W'(abs_mag(MaxW'(coeff), COEFF_W, signed_mode));
    neg_d       = signed_mode & (din[DIN_W-1] ^ coeff[COEFF_W-1]);
    // Counter runs down, so the bit position is the number of steps already retired.
    shamt       = SH_W'((ITER - 1 - 32'(cnt_q)) * RADIX_BITS);
  end

  mult_pp_add #(
    .DIN_W      (DIN_W),
    .RADIX_BITS (RADIX_BITS),
    .PROD_W     (PROD_W),
    .SH_W       (SH_W)
  ) u_pp_add (
    .mcand    (din_mag_q),
    .slice    (coeff_mag_q[RADIX_BITS-1:0]),
    .shamt    (shamt),
    .psum_in  (psum_q),
    .psum_out (psum_next)
  );

  always_comb begin
    signed_prod = PROD_W'(cond_neg(MaxW'(psum_next), neg_q));
    if (smode_q) prod_ext = OUT_W'($signed(signed_prod));
    else         prod_ext = OUT_W'(signed_prod);
  end

`ifdef MULT_ACC_EN
  logic acc_q;
  assign product_d = acc_q ? (product_q + prod_ext) : prod_ext;
`else
  logic unused_acc_en;
  assign unused_acc_en = acc_en;
  assign product_d     = prod_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      din_mag_q   <= '0;
      coeff_mag_q <= '0;
      neg_q       <= 1'b0;
      smode_q     <= 1'b0;
      psum_q      <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef MULT_ACC_EN
      acc_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if ((state_q == StDone) && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
          if (accept) begin
            din_mag_q   <= din_mag_d;
            coeff_mag_q <= coeff_mag_d;
            neg_q       <= neg_d;
            smode_q     <= signed_mode;
            psum_q      <= '0;
            cnt_q       <= CNT_W'(ITER - 1);
            state_q     <= StBusy;
`ifdef MULT_ACC_EN
            acc_q       <= acc_en;
`endif
          end
        end
        StBusy: begin
          psum_q      <= psum_next;
          coeff_mag_q <= coeff_mag_q >> RADIX_BITS;
          cnt_q       <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            product_q   <= product_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_acc.sv
// Randomized self-checking bench for seq_mult_acc: a radix-1 and a radix-4 instance
// compared against an arithmetic reference model.
module tb_seq_mult_acc;

  localparam int unsigned DIN_W   = 12;
  localparam int unsigned COEFF_W = 16;
  localparam int unsigned OUT_W   = 32;

  typedef struct {
    logic [DIN_W-1:0]   d;
    logic [COEFF_W-1:0] c;
    bit                 sm;
    bit                 ac;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready, signed_mode, acc_en, use4;
  logic [DIN_W-1:0]   din;
  logic [COEFF_W-1:0] coeff;

  logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [OUT_W-1:0] product1, product4;
  logic in_ready_s, out_valid_s, busy_s;
  logic [OUT_W-1:0] product_s;

  int checks   = 0;
  int failures = 0;
  logic [OUT_W-1:0] acc_model [2];
  logic [OUT_W-1:0] exp_prod;

  always #5 clk = ~clk;

  assign in_valid1   = in_valid & ~use4;
  assign in_valid4   = in_valid & use4;
  assign out_ready1  = out_ready & ~use4;
  assign out_ready4  = out_ready & use4;
  assign in_ready_s  = use4 ? in_ready4 : in_ready1;
  assign out_valid_s = use4 ? out_valid4 : out_valid1;
  assign busy_s      = use4 ? busy4 : busy1;
  assign product_s   = use4 ? product4 : product1;

  seq_mult_acc u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .din         (din),
    .coeff       (coeff),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .out_valid   (out_valid1),
    .out_ready   (out_ready1),
    .product     (product1),
    .busy        (busy1)
  );

  seq_mult_acc #(
    .RADIX_BITS (4)
  ) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .din         (din),
    .coeff       (coeff),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .product     (product4),
    .busy        (busy4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s (dut%0d): got 0x%0h expected 0x%0h", tag, use4 ? 4 : 1, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_mult(input logic [DIN_W-1:0] d,
                                                input logic [COEFF_W-1:0] c, input bit sm);
    longint a, b;
    a = sm ? longint'($signed(d)) : longint'(d);
    b = sm ? longint'($signed(c)) : longint'(c);
    return OUT_W'(a * b);
  endfunction

  // Called on a negedge where the selected DUT can accept; returns on the negedge after accept.
  task automatic launch(input op_t op);
    logic [OUT_W-1:0] p;
    in_valid    = 1'b1;
    din         = op.d;
    coeff       = op.c;
    signed_mode = op.sm;
    acc_en      = op.ac;
    p = ref_mult(op.d, op.c, op.sm);
`ifdef MULT_ACC_EN
    if (op.ac) p = acc_model[use4] + p;
`endif
    acc_model[use4] = p;
    exp_prod = p;
    #1;
    check_eq("in_ready_at_accept", 64'(in_ready_s), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = DIN_W'($urandom);
    coeff     = COEFF_W'($urandom);
  endtask

  task automatic collect(input bit release_out);
    int cnt;
    cnt = 0;
    check_eq("busy_after_accept", 64'(busy_s), 64'(1));
    check_eq("no_early_valid", 64'(out_valid_s), 64'(0));
    while (!out_valid_s && cnt < 200) begin
      in_valid = 1'($urandom);
      din      = DIN_W'($urandom);
      coeff    = COEFF_W'($urandom);
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    check_eq("latency", 64'(cnt), use4 ? 64'(4) : 64'(16));
    check_eq("product", 64'(product_s), 64'(exp_prod));
    check_eq("in_ready_done", 64'(in_ready_s), 64'(0));
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("valid_drop", 64'(out_valid_s), 64'(0));
      check_eq("product_kept", 64'(product_s), 64'(exp_prod));
    end
  endtask

  function automatic op_t rand_op();
    op_t op;
    op.d  = DIN_W'($urandom);
    op.c  = COEFF_W'($urandom);
    op.sm = 1'($urandom_range(0, 1));
    op.ac = 1'($urandom_range(0, 1));
    return op;
  endfunction

  op_t dir_ops [9] = '{
    '{12'h7FF, 16'h7FFF, 1'b1, 1'b0},
    '{12'h800, 16'h8000, 1'b1, 1'b0},
    '{12'hFFF, 16'h0005, 1'b1, 1'b0},
    '{12'hFFF, 16'hFFFF, 1'b0, 1'b0},
    '{12'h000, 16'h8000, 1'b0, 1'b0},
    '{12'h000, 16'h8000, 1'b1, 1'b0},
    '{12'h002, 16'h0003, 1'b1, 1'b0},
    '{12'h004, 16'h0005, 1'b1, 1'b1},
    '{12'hFFF, 16'h001E, 1'b1, 1'b1}
  };

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int spurious;
    in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0; acc_en = 1'b0; use4 = 1'b0;
    din = '0; coeff = '0;
    acc_model[0] = '0; acc_model[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      use4 = 1'(s);
      #1;
      check_eq("rst_in_ready", 64'(in_ready_s), 64'(1));
      check_eq("rst_out_valid", 64'(out_valid_s), 64'(0));
      check_eq("rst_busy", 64'(busy_s), 64'(0));
      check_eq("rst_product", 64'(product_s), 64'(0));
    end
    use4 = 1'b0;
    @(negedge clk);

    foreach (dir_ops[i]) begin
      launch(dir_ops[i]);
      collect(1'b1);
    end

    // Backpressure, then release and re-accept on the same edge.
    launch(rand_op());
    collect(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(out_valid_s), 64'(1));
      check_eq("hold_product", 64'(product_s), 64'(exp_prod));
      check_eq("hold_in_ready", 64'(in_ready_s), 64'(0));
    end
    out_ready = 1'b1;
    launch(rand_op());
    collect(1'b1);

    for (int i = 0; i < 30; i++) begin
      launch(rand_op());
      collect(1'b1);
    end

    use4 = 1'b1;
    @(negedge clk);
    launch('{12'h003, 16'h0007, 1'b1, 1'b0});
    collect(1'b1);
    for (int i = 0; i < 15; i++) begin
      launch(rand_op());
      collect(1'b1);
    end

    // Reset in the middle of a run.
    launch('{12'h003, 16'h0007, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid_s), 64'(0));
    check_eq("midrst_product", 64'(product_s), 64'(0));
    check_eq("midrst_busy", 64'(busy_s), 64'(0));
    acc_model[0] = '0; acc_model[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_s || busy_s) spurious++;
    end
    check_eq("no_spurious", 64'(spurious), 64'(0));
    launch(rand_op());
    collect(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
